// File: rtl/kx4_capmux_pkg.sv
// Shared types and constants for the KX4 capture-side merge block.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the select FSM state encoding, the SEL_MODE encoding and the
// helper that derives the source-index width from the source count.
package kx4_capmux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } sel_state_e;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  // Source-index width: $clog2(n), never below one bit.
  function automatic int sw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kx4_capmux_gen_if.sv
// Bundle of the per-side capture buses, select handshake and trigger inputs.
// Latency: n/a (wiring only).
// Backpressure: none; SEL_REQ/SEL_ACK is a request/acknowledge pair.
//
// Modports:
//   master - the surroundings: drives SRC_*, SEL_*, trigger inputs, ERR_CLR.
//   slave  - the merge block: drives PRDATA/INT/WAIT, SEL_ACK/SEL_CUR,
//            TTRG2 and CONTERR.
interface kx4_capmux_gen_if import kx4_capmux_pkg::*; #(
  parameter int NSRC = 2,
  parameter int DW   = 16,
  parameter int NINT = 14,
  parameter int HW   = 4,
  parameter int SW   = sw_of(NSRC)
);

  logic [NSRC*DW-1:0]   SRC_PRDATA;
  logic [NSRC*NINT-1:0] SRC_INT;
  logic [NSRC-1:0]      SRC_WAIT;
  logic                 SEL_MODE;
  logic                 SEL_REQ;
  logic [SW-1:0]        SEL_ID;
  logic                 SEL_ACK;
  logic [SW-1:0]        SEL_CUR;
  logic [DW-1:0]        PRDATA;
  logic [NINT-1:0]      INT;
  logic                 WAIT;
  logic                 INTRTC;
  logic [NSRC-1:0]      INTRTDIS;
  logic [NSRC-1:0]      ADTRIG1;
  logic [HW-1:0]        TRG_HOLD;
  logic                 TTRG2;
  logic                 CONTERR;
  logic                 ERR_CLR;

  modport master (
    output SRC_PRDATA, SRC_INT, SRC_WAIT, SEL_MODE, SEL_REQ, SEL_ID,
           INTRTC, INTRTDIS, ADTRIG1, TRG_HOLD, ERR_CLR,
    input  SEL_ACK, SEL_CUR, PRDATA, INT, WAIT, TTRG2, CONTERR
  );

  modport slave (
    input  SRC_PRDATA, SRC_INT, SRC_WAIT, SEL_MODE, SEL_REQ, SEL_ID,
           INTRTC, INTRTDIS, ADTRIG1, TRG_HOLD, ERR_CLR,
    output SEL_ACK, SEL_CUR, PRDATA, INT, WAIT, TTRG2, CONTERR
  );

endinterface

// File: rtl/kx4_capmux_trg.sv
// TTRG2 generator: qualifies A/D and RTC trigger requests, edge-detects, applies holdoff.
// Latency: pulse one cycle after the rising edge of the qualified request.
// Backpressure: none; edges arriving during holdoff are dropped, never deferred.
//
// Ports: clk/rst, adtrig1/intrtc/intrtdis request inputs, trg_hold holdoff
// length, ttrg2 one-cycle registered pulse.
module kx4_capmux_trg #(
  parameter int NSRC = 2,
  parameter int HW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] adtrig1,
  input  logic            intrtc,
  input  logic [NSRC-1:0] intrtdis,
  input  logic [HW-1:0]   trg_hold,
  output logic            ttrg2
);

  logic          raw;
  logic          raw_q;
  logic          rise;
  logic [HW-1:0] hold_cnt;

  // Any side disabling RTC triggering blocks the RTC source entirely.
  assign raw  = (|adtrig1) | (intrtc & ~(|intrtdis));
  assign rise = raw & ~raw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q    <= 1'b0;
      hold_cnt <= '0;
      ttrg2    <= 1'b0;
    end else begin
      raw_q <= raw;
      if (rise && (hold_cnt == '0)) begin
        ttrg2    <= 1'b1;
        hold_cnt <= trg_hold;
      end else begin
        ttrg2 <= 1'b0;
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/kx4_capmux_gen.sv
// KX4 capture-side merge: OR-merges or selects one of NSRC side buses, flags contention, makes TTRG2.
// Latency: PRDATA/INT/WAIT combinational (1 cycle with KX4_CAPMUX_OUTREG_EN); SEL_ACK 1 cycle after WAITs clear.
// Backpressure: a select request is held in PEND while any SRC_WAIT is set; requests outside IDLE are ignored.
//
// Ports: CLK, RESET (async, active high), bus (kx4_capmux_gen_if.slave) carrying
// the per-source capture buses, select handshake, merged outputs, trigger
// inputs/output and the sticky CONTERR flag with its ERR_CLR.
// Build option: define KX4_CAPMUX_OUTREG_EN to register PRDATA, INT and WAIT.
module kx4_capmux_gen import kx4_capmux_pkg::*; #(
  parameter int NSRC = 2,
  parameter int DW   = 16,
  parameter int NINT = 14,
  parameter int HW   = 4,
  parameter int SW   = sw_of(NSRC)
) (
  input  logic             CLK,
  input  logic             RESET,
  kx4_capmux_gen_if.slave  bus
);

  // ---------------------------------------------------------------- select FSM
  sel_state_e    state_q;
  sel_state_e    state_d;
  logic [SW-1:0] pend_q;
  logic [SW-1:0] sel_cur_q;
  logic          pend_valid;
  logic          sel_apply;
  logic          sel_bad;

  assign pend_valid = (int'(pend_q) < NSRC);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      sel_cur_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.SEL_REQ) begin
        pend_q <= bus.SEL_ID;
      end
      if (sel_apply) begin
        sel_cur_q <= pend_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_apply = 1'b0;
    sel_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.SEL_REQ) begin
          state_d = PEND;
        end
      end
      PEND: begin
        // Switch only once every side is quiet so no access is torn.
        if (!(|bus.SRC_WAIT)) begin
          state_d = ACK;
          if (pend_valid) begin
            sel_apply = 1'b1;
          end else begin
            sel_bad = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.SEL_ACK = (state_q == ACK);
  assign bus.SEL_CUR = sel_cur_q;

  // ------------------------------------------------------------- merge paths
  logic [DW-1:0]   or_prdata;
  logic [NINT-1:0] or_int;
  logic            or_wait;
  logic [DW-1:0]   sl_prdata;
  logic [NINT-1:0] sl_int;
  logic            sl_wait;
  logic            wait_seen;
  logic            wait_multi;
  logic            data_seen;
  logic            data_multi;

  always_comb begin
    or_prdata  = '0;
    or_int     = '0;
    or_wait    = 1'b0;
    sl_prdata  = '0;
    sl_int     = '0;
    sl_wait    = 1'b0;
    wait_seen  = 1'b0;
    wait_multi = 1'b0;
    data_seen  = 1'b0;
    data_multi = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      or_prdata = or_prdata | bus.SRC_PRDATA[k*DW +: DW];
      or_int    = or_int    | bus.SRC_INT[k*NINT +: NINT];
      or_wait   = or_wait   | bus.SRC_WAIT[k];
      // A second active source on either wait or data is a contention.
      if (bus.SRC_WAIT[k]) begin
        wait_multi = wait_multi | wait_seen;
        wait_seen  = 1'b1;
      end
      if (|bus.SRC_PRDATA[k*DW +: DW]) begin
        data_multi = data_multi | data_seen;
        data_seen  = 1'b1;
      end
      if (sel_cur_q == SW'(k)) begin
        sl_prdata = bus.SRC_PRDATA[k*DW +: DW];
        sl_int    = bus.SRC_INT[k*NINT +: NINT];
        sl_wait   = bus.SRC_WAIT[k];
      end
    end
  end

  logic [DW-1:0]   mrg_prdata;
  logic [NINT-1:0] mrg_int;
  logic            mrg_wait;

  assign mrg_prdata = (bus.SEL_MODE == MODE_SEL) ? sl_prdata : or_prdata;
  assign mrg_int    = (bus.SEL_MODE == MODE_SEL) ? sl_int    : or_int;
  assign mrg_wait   = (bus.SEL_MODE == MODE_SEL) ? sl_wait   : or_wait;

`ifdef KX4_CAPMUX_OUTREG_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.PRDATA <= '0;
      bus.INT    <= '0;
      bus.WAIT   <= 1'b0;
    end else begin
      bus.PRDATA <= mrg_prdata;
      bus.INT    <= mrg_int;
      bus.WAIT   <= mrg_wait;
    end
  end
`else
  assign bus.PRDATA = mrg_prdata;
  assign bus.INT    = mrg_int;
  assign bus.WAIT   = mrg_wait;
`endif

  // ------------------------------------------------------------- contention
  logic cont_set;
  logic conterr_q;

  assign cont_set = ((bus.SEL_MODE == MODE_OR) && (wait_multi || data_multi)) || sel_bad;

  // A fresh error in the same cycle as a clear must not be lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      conterr_q <= 1'b0;
    end else if (cont_set) begin
      conterr_q <= 1'b1;
    end else if (bus.ERR_CLR) begin
      conterr_q <= 1'b0;
    end
  end

  assign bus.CONTERR = conterr_q;

  // ---------------------------------------------------------------- trigger
  kx4_capmux_trg #(
    .NSRC (NSRC),
    .HW   (HW)
  ) u_trg (
    .clk      (CLK),
    .rst      (RESET),
    .adtrig1  (bus.ADTRIG1),
    .intrtc   (bus.INTRTC),
    .intrtdis (bus.INTRTDIS),
    .trg_hold (bus.TRG_HOLD),
    .ttrg2    (bus.TTRG2)
  );

endmodule
